adc_daisy_reader: RTL

Parametrised successor to the single-shot daisy-chain ADC controller. It drives CONVST/SCK for a chain of `NUM_ADC` SPI ADCs and shifts out `NUM_ADC*ADC_BITS` bits per frame. It adds runtime conversion time, SCK division, burst and continuous acquisition, abort, and a valid/ready frame output with overrun detection. It sits between the ADC pins and the end-point FIFO/pipe logic.

---
 rtl/adc_daisy_pkg.sv | 29 ++
 rtl/adc_daisy_reader_if.sv | 28 ++
 rtl/adc_daisy_shifter.sv | 85 ++++++++
 rtl/adc_daisy_reader.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/adc_daisy_pkg.sv
// Shared types and sizing helpers for the daisy-chain ADC reader.
// Also holds the default chain geometry and timing constants.
package adc_daisy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONV,
    ST_SCK_HI,
    ST_SCK_LO,
    ST_DONE,
    ST_QUIET
  } state_e;

  localparam int unsigned DEF_NUM_ADC      = 3;
  localparam int unsigned DEF_ADC_BITS     = 18;
  localparam int unsigned DEF_SCK_DIV      = 1;
  localparam int unsigned DEF_QUIET_CYCLES = 2;

  localparam int unsigned IDX_W   = 16;
  localparam int unsigned TCONV_W = 8;

  localparam int unsigned DEF_TOTAL     = DEF_NUM_ADC * DEF_ADC_BITS;
  localparam int unsigned DEF_BIT_CNT_W = $clog2(DEF_TOTAL + 1);

  function automatic int unsigned total_bits(input int unsigned n_adc, input int unsigned n_bits);
    return n_adc * n_bits;
  endfunction

endpackage

// File: rtl/adc_daisy_reader_if.sv
// Frame output bus: valid/ready handshake carrying the assembled chain word.
// The reader drives it through the master modport; the consumer uses slave.
interface adc_daisy_reader_if
  import adc_daisy_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_TOTAL
);

  logic              frame_valid;
  logic              frame_ready;
  logic [DATA_W-1:0] frame_data;
  logic [IDX_W-1:0]  frame_idx;

  modport master (
    output frame_valid,
    output frame_data,
    output frame_idx,
    input  frame_ready
  );

  modport slave (
    input  frame_valid,
    input  frame_data,
    input  frame_idx,
    output frame_ready
  );

endinterface

// File: rtl/adc_daisy_shifter.sv
// SCK generator and serial-to-parallel shifter for one frame of the chain.
// A go pulse starts TOTAL SCK pulses; done pulses one cycle after the last low phase.
module adc_daisy_shifter
  import adc_daisy_pkg::*;
#(
  parameter int unsigned TOTAL   = DEF_TOTAL,
  parameter int unsigned SCK_DIV = DEF_SCK_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_go,
  input  logic             i_clear,
  input  logic             i_sdo,
  output logic             o_sck,
  output logic             o_done,
  output logic             o_phase_end_c,
  output logic             o_last_c,
  output logic [TOTAL-1:0] o_word
);

  localparam int unsigned BIT_W = $clog2(TOTAL + 1);
  localparam int unsigned DIV_W = (SCK_DIV < 2) ? 1 : $clog2(SCK_DIV);

  logic             r_active;
  logic             r_hi;
  logic             r_sck;
  logic             r_done;
  logic [DIV_W-1:0] r_div_cnt;
  logic [BIT_W-1:0] r_bit_cnt;
  logic [TOTAL-1:0] r_word;

  assign o_phase_end_c = r_active && (r_div_cnt == DIV_W'(SCK_DIV - 1));
  assign o_last_c      = (r_bit_cnt == BIT_W'(TOTAL));
  assign o_sck         = r_sck;
  assign o_done        = r_done;
  assign o_word        = r_word;

  // Data is captured on the edge that ends each high phase, as SCK falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active  <= 1'b0;
      r_hi      <= 1'b0;
      r_sck     <= 1'b0;
      r_done    <= 1'b0;
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
      r_word    <= '0;
    end else begin
      r_done <= 1'b0;
      if (i_clear) begin
        r_active  <= 1'b0;
        r_hi      <= 1'b0;
        r_sck     <= 1'b0;
        r_div_cnt <= '0;
        r_bit_cnt <= '0;
      end else if (i_go) begin
        r_active  <= 1'b1;
        r_hi      <= 1'b1;
        r_sck     <= 1'b1;
        r_div_cnt <= '0;
        r_bit_cnt <= '0;
        r_word    <= '0;
      end else if (r_active) begin
        if (o_phase_end_c) begin
          r_div_cnt <= '0;
          if (r_hi) begin
            r_word    <= TOTAL'({r_word, i_sdo});
            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            r_hi      <= 1'b0;
            r_sck     <= 1'b0;
          end else if (o_last_c) begin
            r_active <= 1'b0;
            r_done   <= 1'b1;
          end else begin
            r_hi  <= 1'b1;
            r_sck <= 1'b1;
          end
        end else begin
          r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/adc_daisy_reader.sv
// Daisy-chain ADC acquisition controller: CONVST/SCK sequencing, burst and
// continuous modes, abort, and a valid/ready frame register with overrun flag.
module adc_daisy_reader
  import adc_daisy_pkg::*;
#(
  parameter int unsigned NUM_ADC      = DEF_NUM_ADC,
  parameter int unsigned ADC_BITS     = DEF_ADC_BITS,
  parameter int unsigned SCK_DIV      = DEF_SCK_DIV,
  parameter int unsigned QUIET_CYCLES = DEF_QUIET_CYCLES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               mode_cont,
  input  logic [IDX_W-1:0]   num_frames,
  input  logic [TCONV_W-1:0] tconv_cycles,
  output logic               busy,
  output logic               overrun,
  output logic               adc_sck,
  output logic               convst,
  input  logic               adc_sdo,
  adc_daisy_reader_if.master frm
);

  localparam int unsigned TOTAL      = total_bits(NUM_ADC, ADC_BITS);
  localparam int unsigned QUIET_W    = $clog2(QUIET_CYCLES + 1);
  localparam int unsigned WAIT_W     = (QUIET_W > TCONV_W) ? QUIET_W : TCONV_W;
  localparam int unsigned QUIET_LAST = (QUIET_CYCLES > 1) ? (QUIET_CYCLES - 2) : 0;

  state_e             r_state;
  state_e             w_next_state;
  logic               r_mode_cont;
  logic [IDX_W-1:0]   r_num_frames;
  logic [TCONV_W-1:0] r_tconv;
  logic [WAIT_W-1:0]  r_wait_cnt;
  logic [IDX_W-1:0]   r_frame_cnt;
  logic               r_valid;
  logic [TOTAL-1:0]   r_data;
  logic [IDX_W-1:0]   r_idx;
  logic               r_overrun;
  logic               r_busy;
  logic               r_convst;

  logic               w_go;
  logic               w_deliver;
  logic               w_drop;
  logic               w_accept;
  logic               w_launch;
  logic               w_conv_end;
  logic               w_quiet_end;
  logic               w_last_frame;
  logic               w_sck;
  logic               w_sh_done;
  logic               w_phase_end_c;
  logic               w_last_c;
  logic [TOTAL-1:0]   w_word;

  adc_daisy_shifter #(
    .TOTAL   (TOTAL),
    .SCK_DIV (SCK_DIV)
  ) u_shifter (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_go          (w_go),
    .i_clear       (abort),
    .i_sdo         (adc_sdo),
    .o_sck         (w_sck),
    .o_done        (w_sh_done),
    .o_phase_end_c (w_phase_end_c),
    .o_last_c      (w_last_c),
    .o_word        (w_word)
  );

  assign w_accept     = r_valid & frm.frame_ready;
  assign w_conv_end   = (r_wait_cnt == WAIT_W'(r_tconv - TCONV_W'(1)));
  assign w_quiet_end  = (r_wait_cnt == WAIT_W'(QUIET_LAST));
  assign w_last_frame = ((r_frame_cnt + IDX_W'(1)) == r_num_frames);
  assign w_launch     = (r_state == ST_IDLE) && (w_next_state == ST_CONV);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Abort overrides every transition, including a start in the same cycle.
  always_comb begin
    w_next_state = r_state;
    w_go         = 1'b0;
    w_deliver    = 1'b0;
    w_drop       = 1'b0;
    if (abort) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) w_next_state = ST_CONV;
        end
        ST_CONV: begin
          if (w_conv_end) begin
            w_next_state = ST_SCK_HI;
            w_go         = 1'b1;
          end
        end
        ST_SCK_HI: begin
          if (w_phase_end_c) w_next_state = ST_SCK_LO;
        end
        ST_SCK_LO: begin
          if (w_phase_end_c) w_next_state = w_last_c ? ST_DONE : ST_SCK_HI;
        end
        ST_DONE: begin
          w_deliver = w_sh_done && (!r_valid || w_accept);
          w_drop    = w_sh_done && r_valid && !w_accept;
          if (!r_mode_cont && w_last_frame) w_next_state = ST_IDLE;
          else if (QUIET_CYCLES > 1)        w_next_state = ST_QUIET;
          else                              w_next_state = ST_CONV;
        end
        ST_QUIET: begin
          if (w_quiet_end) w_next_state = ST_CONV;
        end
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode_cont  <= 1'b0;
      r_num_frames <= '0;
      r_tconv      <= '0;
      r_wait_cnt   <= '0;
      r_frame_cnt  <= '0;
      r_valid      <= 1'b0;
      r_data       <= '0;
      r_idx        <= '0;
      r_overrun    <= 1'b0;
      r_busy       <= 1'b0;
      r_convst     <= 1'b0;
    end else begin
      r_busy   <= (w_next_state != ST_IDLE);
      r_convst <= (w_next_state == ST_CONV) || (w_next_state == ST_SCK_HI) ||
                  (w_next_state == ST_SCK_LO);

      if (w_next_state != r_state)                          r_wait_cnt <= '0;
      else if ((r_state == ST_CONV) || (r_state == ST_QUIET)) r_wait_cnt <= r_wait_cnt + WAIT_W'(1);

      // Zero burst length or conversion time is promoted to one.
      if (w_launch) begin
        r_mode_cont  <= mode_cont;
        r_num_frames <= (num_frames == '0) ? IDX_W'(1) : num_frames;
        r_tconv      <= (tconv_cycles == '0) ? TCONV_W'(1) : tconv_cycles;
        r_frame_cnt  <= '0;
      end else if (w_deliver || w_drop) begin
        r_frame_cnt <= r_frame_cnt + IDX_W'(1);
      end

      if (w_launch)    r_overrun <= 1'b0;
      else if (w_drop) r_overrun <= 1'b1;

      if (w_deliver) begin
        r_valid <= 1'b1;
        r_data  <= w_word;
        r_idx   <= r_frame_cnt;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign busy            = r_busy;
  assign overrun         = r_overrun;
  assign adc_sck         = w_sck;
  assign convst          = r_convst;
  assign frm.frame_valid = r_valid;
  assign frm.frame_data  = r_data;
  assign frm.frame_idx   = r_idx;

endmodule
